// File: rtl/pcie_pkg.sv
// Shared PCIe block definitions: word layout and the egress drain FSM encoding.
package pcie_pkg;

    localparam int unsigned WORD_SIZE = 6;
    localparam int unsigned VC_BIT    = 5;
    localparam int unsigned DEST_BIT  = 4;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2
    } egr_state_e;

endpackage

// File: rtl/egress_skid_buf.sv
// Two-entry in-order {word, src} buffer; entry 0 is always the head shown downstream.
module egress_skid_buf #(
    parameter int unsigned WIDTH = pcie_pkg::WORD_SIZE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_src,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_word,
    output logic             o_src,
    output logic [1:0]       o_occ
);
    import pcie_pkg::*;

    logic [WIDTH-1:0] r_word [2];
    logic             r_src  [2];
    logic [1:0]       r_occ;

    logic       w_pop;
    logic       w_push;
    logic [1:0] w_wr_pos;
    logic       w_wr_idx;

    always_comb begin
        w_pop    = i_pop && (r_occ != 2'd0);
        w_push   = i_push && ((r_occ != 2'd2) || w_pop);
        // Write slot is computed after the shift caused by a simultaneous pop.
        w_wr_pos = r_occ - {1'b0, w_pop};
        w_wr_idx = w_wr_pos[0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word[0] <= '0;
            r_word[1] <= '0;
            r_src[0]  <= 1'b0;
            r_src[1]  <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            if (w_pop) begin
                r_word[0] <= r_word[1];
                r_src[0]  <= r_src[1];
            end
            if (w_push) begin
                r_word[w_wr_idx] <= i_word;
                r_src[w_wr_idx]  <= i_src;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_word  = r_word[0];
    assign o_src   = r_src[0];
    assign o_occ   = r_occ;

endmodule

// File: rtl/pcie_egress_drain.sv
// Drains destination FIFOs D0/D1 round-robin into one valid/ready stream and flags misrouted words.
// Optional per-source delivery counters are built when SINK_CNT_EN is defined.
module pcie_egress_drain #(
    parameter int unsigned WORD_SIZE = pcie_pkg::WORD_SIZE,
`ifdef SINK_CNT_EN
    parameter int unsigned CNT_W     = pcie_pkg::CNT_W,
`endif
    parameter int unsigned DEST_BIT  = pcie_pkg::DEST_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 d0_empty,
    input  logic                 d1_empty,
    input  logic [WORD_SIZE-1:0] data_out0,
    input  logic [WORD_SIZE-1:0] data_out1,
    output logic                 pop_D0,
    output logic                 pop_D1,
    output logic [WORD_SIZE-1:0] egr_data,
    output logic                 egr_src,
    output logic                 egr_valid,
    input  logic                 egr_ready,
    output logic                 misroute_err,
`ifdef SINK_CNT_EN
    output logic [CNT_W-1:0]     cnt_d0,
    output logic [CNT_W-1:0]     cnt_d1,
`endif
    output logic                 idle_out
);
    import pcie_pkg::*;

    egr_state_e r_state;
    logic       r_idle;
    logic       r_inflight;
    logic       r_inflight_src;
    logic       r_rr_ptr;
    logic       r_misroute;

    logic                 w_valid;
    logic                 w_src;
    logic [WORD_SIZE-1:0] w_word;
    logic [1:0]           w_occ;
    logic                 w_drain;
    logic [2:0]           w_used;
    logic                 w_has_credit;
    logic                 w_d0_rdy;
    logic                 w_d1_rdy;
    logic                 w_issue;
    logic                 w_grant_d1;
    logic [WORD_SIZE-1:0] w_cap_word;

    always_comb begin
        w_d0_rdy   = !d0_empty;
        w_d1_rdy   = !d1_empty;
        w_drain    = w_valid && egr_ready;
        w_used     = {1'b0, w_occ} + {2'b0, r_inflight};
        // A word leaving this cycle frees its slot, which sustains one pop per cycle.
        w_has_credit = w_used < (3'd2 + {2'b0, w_drain});
        w_issue    = (r_state == StActive) && enable && w_has_credit && (w_d0_rdy || w_d1_rdy);
        w_grant_d1 = (w_d0_rdy && w_d1_rdy) ? r_rr_ptr : w_d1_rdy;
        w_cap_word = r_inflight_src ? data_out1 : data_out0;
    end

    assign pop_D0 = w_issue && !w_grant_d1;
    assign pop_D1 = w_issue && w_grant_d1;

    egress_skid_buf #(
        .WIDTH (WORD_SIZE)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (r_inflight),
        .i_word  (w_cap_word),
        .i_src   (r_inflight_src),
        .i_pop   (w_drain),
        .o_valid (w_valid),
        .o_word  (w_word),
        .o_src   (w_src),
        .o_occ   (w_occ)
    );

    assign egr_valid    = w_valid;
    assign egr_data     = w_word;
    assign egr_src      = w_src;
    assign misroute_err = r_misroute;
    assign idle_out     = r_idle;

    // Read-return tracking, arbitration pointer and misroute detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight     <= 1'b0;
            r_inflight_src <= 1'b0;
            r_rr_ptr       <= 1'b0;
            r_misroute     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_src <= w_grant_d1;
                r_rr_ptr       <= !w_grant_d1;
            end
            if (r_inflight && (w_cap_word[DEST_BIT] != r_inflight_src)) begin
                r_misroute <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    if (enable && (w_d0_rdy || w_d1_rdy)) begin
                        r_state <= StActive;
                        r_idle  <= 1'b0;
                    end
                end
                StActive: begin
                    if (!enable) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (enable) begin
                        r_state <= StActive;
                    end else if (!r_inflight && (w_occ == 2'd0)) begin
                        r_state <= StIdle;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SINK_CNT_EN
    logic [CNT_W-1:0] r_cnt_d0;
    logic [CNT_W-1:0] r_cnt_d1;

    // Counters wrap naturally; no saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_d0 <= '0;
            r_cnt_d1 <= '0;
        end else if (w_drain) begin
            if (w_src) begin
                r_cnt_d1 <= r_cnt_d1 + 1'b1;
            end else begin
                r_cnt_d0 <= r_cnt_d0 + 1'b1;
            end
        end
    end

    assign cnt_d0 = r_cnt_d0;
    assign cnt_d1 = r_cnt_d1;
`endif

endmodule
